// File: rtl/breakout_pkg.sv
// Shared Breakout definitions: brick wall geometry, wall controller states and
// a saturating two-digit BCD increment. The brick wall and the colour mapper
// both import this package, so the two always agree on where each brick sits.
package breakout_pkg;

    // Brick geometry in screen pixels
    localparam logic [10:0] WALL_TOP     = 11'd64;   // y of the top edge of row 0
    localparam int          BRICK_W_LOG2 = 32'd6;    // 64 px wide bricks
    localparam int          BRICK_H_LOG2 = 32'd4;    // 16 px tall bricks
    localparam int          ROWS         = 32'd4;
    localparam int          COLS         = 32'd10;
    localparam int          NUM_BRICKS   = 32'd40;

    // Wall extents used for the probe range checks
    localparam logic [10:0] WALL_W       = 11'd640;  // COLS bricks wide
    localparam logic [10:0] WALL_H       = 11'd64;   // ROWS bricks tall

    // Frames after a hit during which no further hit is accepted
    localparam logic [1:0]  COOLDOWN     = 2'd2;

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        COOL = 2'd1,
        WON  = 2'd2
    } wall_state_t;

    // Add one to a two-digit BCD value, carrying into the tens digit and
    // holding at 99 rather than wrapping.
    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99) begin
            r = 8'h99;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/brick_probe.sv
// Maps one probe point on the ball outline to a brick slot.
// Ports:
//   ok_i    - low when forming the point underflowed (point is off-screen)
//   px_i    - probe x, 11 bits so that x + size never wraps
//   py_i    - probe y, 11 bits
//   valid_o - point lies inside the brick wall area
//   idx_o   - brick index row*COLS + col; only meaningful while valid_o is high
module brick_probe
    import breakout_pkg::*;
(
    input  logic        ok_i,
    input  logic [10:0] px_i,
    input  logic [10:0] py_i,
    output logic        valid_o,
    output logic [5:0]  idx_o
);

    logic [10:0] yoff_s;
    logic [1:0]  row_s;
    logic [3:0]  col_s;

    // A point above the wall wraps yoff_s to a large value, so a single
    // unsigned compare rejects both "above" and "below" the wall.
    always_comb begin
        yoff_s  = py_i - WALL_TOP;
        valid_o = ok_i && (px_i < WALL_W) && (yoff_s < WALL_H);
        row_s   = yoff_s[BRICK_H_LOG2 +: 2];
        col_s   = px_i[BRICK_W_LOG2 +: 4];
        idx_o   = ({4'd0, row_s} * 6'd10) + {2'd0, col_s};
    end

endmodule

// File: rtl/brick_wall.sv
// Breakout brick wall: holds which bricks are still standing, checks the four
// extreme points of the ball against them once per frame, clears at most one
// struck brick per frame, and reports bounce requests, score and win status.
// Ports:
//   frame_clk   - frame-rate clock
//   Reset       - asynchronous, active-high reset
//   BallX/Y/S   - ball centre and half-size from the motion stage
//   restart     - synchronous level; refills the wall and clears the score
//   brick_alive - bit row*COLS+col set while that brick stands
//   bounce_x/y  - one-frame requests to negate the ball's X / Y motion
//   score       - two-digit BCD count of cleared bricks
//   bricks_left - bricks still standing
//   game_won    - high once every brick is gone
module brick_wall
    import breakout_pkg::*;
(
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [9:0]  BallX,
    input  logic [9:0]  BallY,
    input  logic [9:0]  BallS,
    input  logic        restart,
    output logic [39:0] brick_alive,
    output logic        bounce_x,
    output logic        bounce_y,
    output logic [7:0]  score,
    output logic [5:0]  bricks_left,
    output logic        game_won
);

    localparam logic [39:0] FULL_WALL = 40'hFF_FFFF_FFFF;
    localparam logic [5:0]  ALL_BRICKS = 6'd40;

    wall_state_t state_q, state_d;
    logic [39:0] alive_q, alive_d;
    logic [7:0]  score_q, score_d;
    logic [5:0]  left_q,  left_d;
    logic [1:0]  cnt_q,   cnt_d;
    logic        bx_q, bx_d, by_q, by_d, won_q, won_d;

    logic [10:0] bx_s, by_s, bs_s;
    logic [10:0] ty_s, byy_s, lx_s, rx_s;
    logic        t_ok_s, l_ok_s;
    logic [3:0]  valid_s, hit_s;
    logic [5:0]  idx_t_s, idx_b_s, idx_l_s, idx_r_s, sel_idx_s;
    logic        any_hit_s;

    // Probe points: top, bottom, left, right of the ball. Underflow is
    // detected by comparing before subtracting; sums are 11 bits so they
    // cannot wrap back onto the screen.
    always_comb begin
        bx_s   = {1'b0, BallX};
        by_s   = {1'b0, BallY};
        bs_s   = {1'b0, BallS};
        t_ok_s = (BallY >= BallS);
        l_ok_s = (BallX >= BallS);
        ty_s   = by_s - bs_s;
        byy_s  = by_s + bs_s;
        lx_s   = bx_s - bs_s;
        rx_s   = bx_s + bs_s;
    end

    brick_probe u_probe_t (.ok_i(t_ok_s), .px_i(bx_s), .py_i(ty_s),  .valid_o(valid_s[0]), .idx_o(idx_t_s));
    brick_probe u_probe_b (.ok_i(1'b1),   .px_i(bx_s), .py_i(byy_s), .valid_o(valid_s[1]), .idx_o(idx_b_s));
    brick_probe u_probe_l (.ok_i(l_ok_s), .px_i(lx_s), .py_i(by_s),  .valid_o(valid_s[2]), .idx_o(idx_l_s));
    brick_probe u_probe_r (.ok_i(1'b1),   .px_i(rx_s), .py_i(by_s),  .valid_o(valid_s[3]), .idx_o(idx_r_s));

    // A probe only hits a standing brick; cleared bricks let the ball through.
    // Top wins over bottom over left over right.
    always_comb begin
        hit_s[0]  = valid_s[0] && alive_q[idx_t_s];
        hit_s[1]  = valid_s[1] && alive_q[idx_b_s];
        hit_s[2]  = valid_s[2] && alive_q[idx_l_s];
        hit_s[3]  = valid_s[3] && alive_q[idx_r_s];
        any_hit_s = |hit_s;
        if (hit_s[0]) begin
            sel_idx_s = idx_t_s;
        end else if (hit_s[1]) begin
            sel_idx_s = idx_b_s;
        end else if (hit_s[2]) begin
            sel_idx_s = idx_l_s;
        end else if (hit_s[3]) begin
            sel_idx_s = idx_r_s;
        end else begin
            sel_idx_s = 6'd0;
        end
    end

    // Next-state logic for the wall controller and all registered outputs.
    always_comb begin
        state_d = state_q;
        alive_d = alive_q;
        score_d = score_q;
        left_d  = left_q;
        cnt_d   = cnt_q;
        bx_d    = 1'b0;
        by_d    = 1'b0;
        won_d   = 1'b0;
        if (restart) begin
            state_d = PLAY;
            alive_d = FULL_WALL;
            score_d = 8'h00;
            left_d  = ALL_BRICKS;
            cnt_d   = 2'd0;
        end else begin
            case (state_q)
                PLAY: begin
                    if (any_hit_s) begin
                        alive_d[sel_idx_s] = 1'b0;
                        score_d = bcd_inc_sat(score_q);
                        if (left_q != 6'd0) begin
                            left_d = left_q - 6'd1;
                        end else begin
                            left_d = 6'd0;
                        end
                        by_d = hit_s[0] | hit_s[1];
                        bx_d = ~(hit_s[0] | hit_s[1]);
                        // Clearing the last brick ends the game instead of cooling down
                        if (left_q == 6'd1) begin
                            state_d = WON;
                            cnt_d   = 2'd0;
                        end else begin
                            state_d = COOL;
                            cnt_d   = COOLDOWN;
                        end
                    end else begin
                        state_d = PLAY;
                    end
                end
                COOL: begin
                    // The frame on which the count reaches zero still ignores hits
                    if (cnt_q <= 2'd1) begin
                        state_d = PLAY;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                WON: begin
                    state_d = WON;
                end
                default: begin
                    state_d = PLAY;
                    cnt_d   = 2'd0;
                end
            endcase
        end
        won_d = (state_d == WON);
    end

    // State and output registers.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q <= PLAY;
            alive_q <= FULL_WALL;
            score_q <= 8'h00;
            left_q  <= ALL_BRICKS;
            cnt_q   <= 2'd0;
            bx_q    <= 1'b0;
            by_q    <= 1'b0;
            won_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            alive_q <= alive_d;
            score_q <= score_d;
            left_q  <= left_d;
            cnt_q   <= cnt_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            won_q   <= won_d;
        end
    end

    assign brick_alive = alive_q;
    assign bounce_x    = bx_q;
    assign bounce_y    = by_q;
    assign score       = score_q;
    assign bricks_left = left_q;
    assign game_won    = won_q;

endmodule

// File: tb/tb_brick_wall.sv
// Self-checking bench for brick_wall: a frame-level behavioural model of the
// game rules is compared against the DUT every frame, plus directed scenarios
// with hand-computed expectations.
module tb_brick_wall;

    logic        frame_clk = 1'b0;
    logic        Reset;
    logic [9:0]  BallX, BallY, BallS;
    logic        restart;
    logic [39:0] brick_alive;
    logic        bounce_x, bounce_y, game_won;
    logic [7:0]  score;
    logic [5:0]  bricks_left;

    brick_wall dut (
        .frame_clk(frame_clk), .Reset(Reset),
        .BallX(BallX), .BallY(BallY), .BallS(BallS), .restart(restart),
        .brick_alive(brick_alive), .bounce_x(bounce_x), .bounce_y(bounce_y),
        .score(score), .bricks_left(bricks_left), .game_won(game_won)
    );

    always #5 frame_clk = ~frame_clk;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Model state: standing bricks, bricks cleared, frames still ignoring hits
    logic [39:0] m_alive;
    int          m_cleared;
    int          m_block;
    bit          m_won, m_bx, m_by;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Brick index under a point, or -1 when the point is outside the wall
    function automatic int probe_idx(input int x, input int y);
        if (x < 0 || x >= 640 || y < 64 || y >= 128) return -1;
        return ((y - 64) / 16) * 10 + (x / 64);
    endfunction

    function automatic logic [7:0] exp_score(input int n);
        if (n >= 99) return 8'h99;
        return 8'((n / 10) * 16 + (n % 10));
    endfunction

    task automatic model_reset();
        m_alive   = 40'hFF_FFFF_FFFF;
        m_cleared = 0;
        m_block   = 0;
        m_won     = 1'b0;
        m_bx      = 1'b0;
        m_by      = 1'b0;
    endtask

    task automatic model_step();
        int x, y, s;
        int cand[4];
        if (Reset || restart) begin
            model_reset();
        end else begin
            m_bx = 1'b0;
            m_by = 1'b0;
            x = int'(BallX); y = int'(BallY); s = int'(BallS);
            cand[0] = probe_idx(x, y - s);
            cand[1] = probe_idx(x, y + s);
            cand[2] = probe_idx(x - s, y);
            cand[3] = probe_idx(x + s, y);
            if (m_won) begin
                m_block = 0;
            end else if (m_block > 0) begin
                m_block--;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (cand[k] >= 0 && m_alive[cand[k]]) begin
                        m_alive[cand[k]] = 1'b0;
                        m_cleared++;
                        if (k < 2) m_by = 1'b1; else m_bx = 1'b1;
                        if (m_cleared == 40) m_won = 1'b1; else m_block = 2;
                        break;
                    end
                end
            end
        end
    endtask

    // Model advances on every clock edge and on an asynchronous reset
    initial begin
        model_reset();
        forever begin
            @(posedge frame_clk or posedge Reset);
            model_step();
        end
    end

    // Per-frame comparison of every output against the model
    always @(negedge frame_clk) begin
        if (check_en) begin
            chk("m_alive", {24'd0, brick_alive}, {24'd0, m_alive});
            chk("m_score", {56'd0, score}, {56'd0, exp_score(m_cleared)});
            chk("m_left", {58'd0, bricks_left}, 64'(40 - m_cleared));
            chk("m_won", {63'd0, game_won}, {63'd0, m_won});
            chk("m_bx", {63'd0, bounce_x}, {63'd0, m_bx});
            chk("m_by", {63'd0, bounce_y}, {63'd0, m_by});
        end
    end

    task automatic cyc();
        @(negedge frame_clk);
        #1;
    endtask

    task automatic away();
        BallX = 10'd0; BallY = 10'd500; BallS = 10'd0;
    endtask

    task automatic ball(input int x, input int y, input int s);
        BallX = 10'(x); BallY = 10'(y); BallS = 10'(s);
    endtask

    initial begin
        Reset = 1'b0; restart = 1'b0; away();
        #2 Reset = 1'b1;
        #1 check_en = 1'b1;
        repeat (2) cyc();
        Reset = 1'b0;
        cyc();
        chk("rst_alive", {24'd0, brick_alive}, 64'hFF_FFFF_FFFF);
        chk("rst_score", {56'd0, score}, 64'h00);
        chk("rst_left", {58'd0, bricks_left}, 64'd40);
        chk("rst_won", {63'd0, game_won}, 64'd0);
        chk("rst_pulse", {62'd0, bounce_x, bounce_y}, 64'd0);

        // Top probe at y=126 lands in brick 31
        ball(100, 130, 4); cyc();
        chk("t_bit31", {63'd0, brick_alive[31]}, 64'd0);
        chk("t_by", {63'd0, bounce_y}, 64'd1);
        chk("t_bx", {63'd0, bounce_x}, 64'd0);
        chk("t_score", {56'd0, score}, 64'h01);
        chk("t_left", {58'd0, bricks_left}, 64'd39);

        // Cooldown: brick 32 survives two frames, cleared on the third
        ball(160, 130, 4); cyc();
        chk("cool1_by", {63'd0, bounce_y}, 64'd0);
        chk("cool1_bit32", {63'd0, brick_alive[32]}, 64'd1);
        cyc();
        chk("cool2_bit32", {63'd0, brick_alive[32]}, 64'd1);
        cyc();
        chk("cool3_bit32", {63'd0, brick_alive[32]}, 64'd0);
        chk("cool3_by", {63'd0, bounce_y}, 64'd1);
        chk("cool3_score", {56'd0, score}, 64'h02);

        // Pre-clear brick 21, then only the right probe finds a brick (22)
        away(); cyc(); cyc();
        ball(100, 104, 0); cyc();
        chk("pre_bit21", {63'd0, brick_alive[21]}, 64'd0);
        away(); cyc(); cyc();
        ball(124, 104, 4); cyc();
        chk("r_bit22", {63'd0, brick_alive[22]}, 64'd0);
        chk("r_bx", {63'd0, bounce_x}, 64'd1);
        chk("r_by", {63'd0, bounce_y}, 64'd0);
        chk("r_score", {56'd0, score}, 64'h04);
        chk("r_left", {58'd0, bricks_left}, 64'd36);
        away(); cyc(); cyc();

        // Randomized play with occasional restarts and wide sizes
        repeat (600) begin
            restart = ($urandom_range(0, 63) == 0);
            BallX = 10'($urandom_range(0, 1023));
            BallY = 10'($urandom_range(40, 160));
            if ($urandom_range(0, 7) == 0) BallS = 10'($urandom_range(0, 1023));
            else BallS = 10'($urandom_range(0, 24));
            cyc();
        end

        // Clear the whole wall brick by brick
        restart = 1'b1; away(); cyc();
        restart = 1'b0;
        for (int i = 0; i < 40; i++) begin
            ball((i % 10) * 64 + 32, 64 + (i / 10) * 16 + 8, 0);
            cyc();
            if (i < 39) begin
                away(); cyc(); cyc();
            end
        end
        chk("win_won", {63'd0, game_won}, 64'd1);
        chk("win_score", {56'd0, score}, 64'h40);
        chk("win_left", {58'd0, bricks_left}, 64'd0);
        chk("win_alive", {24'd0, brick_alive}, 64'd0);
        ball(32, 72, 8); cyc(); cyc();
        chk("won_pulse", {62'd0, bounce_x, bounce_y}, 64'd0);
        chk("won_hold", {63'd0, game_won}, 64'd1);
        restart = 1'b1; cyc();
        restart = 1'b0;
        chk("rs_alive", {24'd0, brick_alive}, 64'hFF_FFFF_FFFF);
        chk("rs_score", {56'd0, score}, 64'h00);
        chk("rs_won", {63'd0, game_won}, 64'd0);
        chk("rs_left", {58'd0, bricks_left}, 64'd40);

        // Reset during cooldown, then restart colliding with a valid hit
        away(); cyc();
        ball(100, 130, 4); cyc();
        away();
        Reset = 1'b1;
        #1 chk("arst_alive", {24'd0, brick_alive}, 64'hFF_FFFF_FFFF);
        chk("arst_score", {56'd0, score}, 64'h00);
        chk("arst_by", {63'd0, bounce_y}, 64'd0);
        cyc();
        Reset = 1'b0; restart = 1'b1; ball(100, 130, 4);
        cyc();
        chk("rsh_alive", {24'd0, brick_alive}, 64'hFF_FFFF_FFFF);
        chk("rsh_pulse", {62'd0, bounce_x, bounce_y}, 64'd0);
        chk("rsh_left", {58'd0, bricks_left}, 64'd40);
        restart = 1'b0; cyc();
        chk("after_bit31", {63'd0, brick_alive[31]}, 64'd0);
        chk("after_by", {63'd0, bounce_y}, 64'd1);
        away(); cyc();

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
